// File: rtl/rf_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// rf_seq_pkg
// Shared types and constants for the register-file command sequencer:
//   op_e      - command operation codes
//   state_e   - sequencer FSM states
//   REG_*     - register codes (T1..T4 = 000..011, R1..R4 = 100..111),
//               identical to the O1Sel encoding of the register file
//   FUNSEL_*  - register-file FunSel function codes
//   funsel_for_op() - FunSel value to present while strobing for an op
// ---------------------------------------------------------------------------
package rf_seq_pkg;

    typedef enum logic [2:0] {
        OP_CLR  = 3'b000,
        OP_LDI  = 3'b001,
        OP_INC  = 3'b010,
        OP_DEC  = 3'b011,
        OP_MOV  = 3'b100,
        OP_RD   = 3'b101,
        OP_ADDN = 3'b110,
        OP_SUBN = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_REPEAT = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    localparam logic [2:0] REG_T1 = 3'b000;
    localparam logic [2:0] REG_T2 = 3'b001;
    localparam logic [2:0] REG_T3 = 3'b010;
    localparam logic [2:0] REG_T4 = 3'b011;
    localparam logic [2:0] REG_R1 = 3'b100;
    localparam logic [2:0] REG_R2 = 3'b101;
    localparam logic [2:0] REG_R3 = 3'b110;
    localparam logic [2:0] REG_R4 = 3'b111;

    localparam logic [1:0] FUNSEL_CLR = 2'b00;
    localparam logic [1:0] FUNSEL_LD  = 2'b01;
    localparam logic [1:0] FUNSEL_DEC = 2'b10;
    localparam logic [1:0] FUNSEL_INC = 2'b11;

    // ADDN/SUBN are built from repeated INC/DEC strobes, so they share codes.
    function automatic logic [1:0] funsel_for_op(input op_e op);
        logic [1:0] fs;
        case (op)
            OP_CLR:           fs = FUNSEL_CLR;
            OP_LDI, OP_MOV:   fs = FUNSEL_LD;
            OP_INC, OP_ADDN:  fs = FUNSEL_INC;
            OP_DEC, OP_SUBN:  fs = FUNSEL_DEC;
            default:          fs = FUNSEL_CLR;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/rf_cmd_sequencer_if.sv
// ---------------------------------------------------------------------------
// rf_cmd_sequencer_if
// Command and read-response handshake bundle of the sequencer.
//   cmd_valid/cmd_ready           - command offer / accept
//   cmd_op, cmd_dst, cmd_src, cmd_imm - command fields
//   rsp_valid/rsp_ready, rsp_data - read (RD) response
// Modports:
//   master - the command issuer (drives commands, consumes responses)
//   slave  - the sequencer
// ---------------------------------------------------------------------------
interface rf_cmd_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_dst;
    logic [2:0] cmd_src;
    logic [7:0] cmd_imm;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ready;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/rf_cmd_sequencer_sel_decoder.sv
// ---------------------------------------------------------------------------
// rf_sel_decoder
// Purely combinational write-strobe decoder.
//   i_code [2:0] - register code (T1..T4 = 000..011, R1..R4 = 100..111)
//   i_en         - strobe enable; both outputs are zero when low
//   o_rsel [3:0] - R-bank select, bit3 = R1 ... bit0 = R4
//   o_tsel [3:0] - T-bank select, bit3 = T1 ... bit0 = T4
// ---------------------------------------------------------------------------
import rf_seq_pkg::*;

module rf_sel_decoder (
    input  logic [2:0] i_code,
    input  logic       i_en,
    output logic [3:0] o_rsel,
    output logic [3:0] o_tsel
);

    logic [3:0] w_onehot;

    // Low two code bits pick the register within a bank, MSB-first.
    always_comb begin
        w_onehot = 4'b0000;
        case (i_code[1:0])
            2'b00:   w_onehot = 4'b1000;
            2'b01:   w_onehot = 4'b0100;
            2'b10:   w_onehot = 4'b0010;
            default: w_onehot = 4'b0001;
        endcase
    end

    always_comb begin
        o_rsel = 4'b0000;
        o_tsel = 4'b0000;
        if (i_en) begin
            if (i_code >= REG_R1) begin
                o_rsel = w_onehot;
            end else begin
                o_tsel = w_onehot;
            end
        end
    end

endmodule

// File: rtl/rf_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// rf_cmd_sequencer
// Accepts register-file commands over a valid/ready handshake and turns them
// into register-file control sequences (select strobes, FunSel, RFInput,
// O1Sel reads), returning RD results over a response handshake.
// Ports:
//   i_clk       - clock, all state updates on the rising edge
//   i_rst_n     - synchronous active-low reset
//   bus         - command / response handshake (slave side)
//   i_rd_data   - register-file Output1
//   o_FunSel    - register-file function select
//   o_RSel      - R-bank load strobe (bit3 = R1 ... bit0 = R4)
//   o_TSel      - T-bank load strobe (bit3 = T1 ... bit0 = T4)
//   o_O1Sel     - register-file Output1 select
//   o_RFInput   - register-file load data
//   o_busy      - high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
import rf_seq_pkg::*;

module rf_cmd_sequencer (
    input  logic                i_clk,
    input  logic                i_rst_n,
    rf_cmd_sequencer_if.slave   bus,
    input  logic [7:0]          i_rd_data,
    output logic [1:0]          o_FunSel,
    output logic [3:0]          o_RSel,
    output logic [3:0]          o_TSel,
    output logic [2:0]          o_O1Sel,
    output logic [7:0]          o_RFInput,
    output logic                o_busy
);

    state_e     r_state;
    state_e     w_next_state;
    op_e        r_op;
    logic [2:0] r_dst;
    logic [2:0] r_src;
    logic [7:0] r_imm;
    logic [7:0] r_cnt;
    logic [7:0] r_data;

    logic       w_accept;
    logic       w_strobe;
    op_e        w_cmd_op;

    assign w_cmd_op = op_e'(bus.cmd_op);
    assign w_accept = bus.cmd_valid && (r_state == ST_IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_CLR;
            r_dst   <= 3'b000;
            r_src   <= 3'b000;
            r_imm   <= 8'h00;
            r_cnt   <= 8'h00;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_next_state;
            // The counter is loaded with the repeat count on acceptance and
            // counts strobes down while in REPEAT.
            if (w_accept) begin
                r_op  <= w_cmd_op;
                r_dst <= bus.cmd_dst;
                r_src <= bus.cmd_src;
                r_imm <= bus.cmd_imm;
                r_cnt <= bus.cmd_imm;
            end else if (r_state == ST_REPEAT) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (r_state == ST_READ) begin
                r_data <= i_rd_data;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_cmd_op)
                        OP_MOV, OP_RD:    w_next_state = ST_READ;
                        OP_ADDN, OP_SUBN: w_next_state = (bus.cmd_imm != 8'd0) ? ST_REPEAT : ST_IDLE;
                        default:          w_next_state = ST_WRITE;
                    endcase
                end
            end
            ST_READ:   w_next_state = (r_op == OP_MOV) ? ST_WRITE : ST_RESP;
            ST_WRITE:  w_next_state = ST_IDLE;
            // r_cnt holds the strobes still to issue, including this one.
            ST_REPEAT: w_next_state = (r_cnt <= 8'd1) ? ST_IDLE : ST_REPEAT;
            ST_RESP:   w_next_state = bus.rsp_ready ? ST_IDLE : ST_RESP;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    assign w_strobe = (r_state == ST_WRITE) || (r_state == ST_REPEAT);

    rf_sel_decoder u_sel_decoder (
        .i_code (r_dst),
        .i_en   (w_strobe),
        .o_rsel (o_RSel),
        .o_tsel (o_TSel)
    );

    always_comb begin
        o_FunSel      = FUNSEL_CLR;
        o_RFInput     = 8'h00;
        o_O1Sel       = 3'b000;
        o_busy        = (r_state != ST_IDLE);
        bus.cmd_ready = (r_state == ST_IDLE);
        bus.rsp_valid = (r_state == ST_RESP);
        bus.rsp_data  = 8'h00;
        if (w_strobe) begin
            o_FunSel = funsel_for_op(r_op);
        end
        if (r_state == ST_WRITE && r_op == OP_LDI) begin
            o_RFInput = r_imm;
        end else if (r_state == ST_WRITE && r_op == OP_MOV) begin
            o_RFInput = r_data;
        end
        if (r_state == ST_READ) begin
            o_O1Sel = r_src;
        end
        if (r_state == ST_RESP) begin
            bus.rsp_data = r_data;
        end
    end

endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rf_cmd_sequencer
// Directed self-checking bench for rf_cmd_sequencer. Timing is referenced
// to the acceptance edge T: outputs are sampled 1 time unit after each
// rising edge, so a sample taken right after applyStimulus returns shows
// cycle T+1.
// ---------------------------------------------------------------------------
module tb_rf_cmd_sequencer;

    logic       clock;
    logic       resetN;
    logic [7:0] rdData;
    logic [1:0] funSel;
    logic [3:0] rSel;
    logic [3:0] tSel;
    logic [2:0] o1Sel;
    logic [7:0] rfInput;
    logic       busy;

    int totalChecks = 0;
    int badChecks   = 0;

    rf_cmd_sequencer_if bus ();

    rf_cmd_sequencer dut (
        .i_clk     (clock),
        .i_rst_n   (resetN),
        .bus       (bus),
        .i_rd_data (rdData),
        .o_FunSel  (funSel),
        .o_RSel    (rSel),
        .o_TSel    (tSel),
        .o_O1Sel   (o1Sel),
        .o_RFInput (rfInput),
        .o_busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        totalChecks++;
        assert (observed === expected) else begin
            badChecks++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offers one command for a single edge, then scrambles the fields so any
    // use of the live inputs after acceptance shows up in the outputs.
    task automatic applyStimulus(input logic [2:0] op, input logic [2:0] dst,
                                 input logic [2:0] src, input logic [7:0] imm);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_dst   = dst;
        bus.cmd_src   = src;
        bus.cmd_imm   = imm;
        nextCycle();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ~op;
        bus.cmd_dst   = ~dst;
        bus.cmd_src   = ~src;
        bus.cmd_imm   = ~imm;
    endtask

    logic [2:0] tblOp   [3] = '{3'b000, 3'b010, 3'b011};
    logic [2:0] tblDst  [3] = '{3'b000, 3'b101, 3'b010};
    logic [3:0] tblRSel [3] = '{4'b0000, 4'b0100, 4'b0000};
    logic [3:0] tblTSel [3] = '{4'b1000, 4'b0000, 4'b0010};
    logic [1:0] tblFun  [3] = '{2'b00, 2'b11, 2'b10};

    initial begin
        resetN        = 1'b0;
        rdData        = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_dst   = 3'b000;
        bus.cmd_src   = 3'b000;
        bus.cmd_imm   = 8'h00;
        bus.rsp_ready = 1'b0;

        // Reset state
        nextCycle();
        nextCycle();
        checkOutput("rst_busy",    {7'd0, busy}, 8'h00);
        checkOutput("rst_rsel",    {4'd0, rSel}, 8'h00);
        checkOutput("rst_tsel",    {4'd0, tSel}, 8'h00);
        checkOutput("rst_funsel",  {6'd0, funSel}, 8'h00);
        checkOutput("rst_o1sel",   {5'd0, o1Sel}, 8'h00);
        checkOutput("rst_rfinput", rfInput, 8'h00);
        checkOutput("rst_rspv",    {7'd0, bus.rsp_valid}, 8'h00);
        resetN = 1'b1;
        nextCycle();
        checkOutput("rel_ready",   {7'd0, bus.cmd_ready}, 8'h01);

        // LDI R1 <- 5A
        applyStimulus(3'b001, 3'b100, 3'b000, 8'h5A);
        checkOutput("ldi_rsel",    {4'd0, rSel}, 8'h08);
        checkOutput("ldi_tsel",    {4'd0, tSel}, 8'h00);
        checkOutput("ldi_funsel",  {6'd0, funSel}, 8'h01);
        checkOutput("ldi_rfinput", rfInput, 8'h5A);
        checkOutput("ldi_ready1",  {7'd0, bus.cmd_ready}, 8'h00);
        nextCycle();
        checkOutput("ldi_ready2",  {7'd0, bus.cmd_ready}, 8'h01);
        checkOutput("ldi_rsel2",   {4'd0, rSel}, 8'h00);
        checkOutput("ldi_rfin2",   rfInput, 8'h00);

        // CLR / INC / DEC single strobes
        for (int i = 0; i < 3; i++) begin
            applyStimulus(tblOp[i], tblDst[i], 3'b000, 8'h00);
            checkOutput($sformatf("single%0d_rsel", i), {4'd0, rSel}, {4'd0, tblRSel[i]});
            checkOutput($sformatf("single%0d_tsel", i), {4'd0, tSel}, {4'd0, tblTSel[i]});
            checkOutput($sformatf("single%0d_fun", i),  {6'd0, funSel}, {6'd0, tblFun[i]});
            nextCycle();
            checkOutput($sformatf("single%0d_ready", i), {7'd0, bus.cmd_ready}, 8'h01);
            checkOutput($sformatf("single%0d_idle_tsel", i), {4'd0, tSel}, 8'h00);
        end

        // ADDN T4 += 3
        applyStimulus(3'b110, 3'b011, 3'b000, 8'd3);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("addn_tsel%0d", i),  {4'd0, tSel}, 8'h01);
            checkOutput($sformatf("addn_fun%0d", i),   {6'd0, funSel}, 8'h03);
            checkOutput($sformatf("addn_ready%0d", i), {7'd0, bus.cmd_ready}, 8'h00);
            nextCycle();
        end
        checkOutput("addn_ready_end", {7'd0, bus.cmd_ready}, 8'h01);
        checkOutput("addn_tsel_end",  {4'd0, tSel}, 8'h00);
        checkOutput("addn_fun_end",   {6'd0, funSel}, 8'h00);

        // ADDN imm=0
        applyStimulus(3'b110, 3'b010, 3'b000, 8'd0);
        checkOutput("addn0_ready", {7'd0, bus.cmd_ready}, 8'h01);
        checkOutput("addn0_busy",  {7'd0, busy}, 8'h00);
        checkOutput("addn0_tsel",  {4'd0, tSel}, 8'h00);
        checkOutput("addn0_rsel",  {4'd0, rSel}, 8'h00);

        // MOV R4 <- T2, Output1 returns C3
        rdData = 8'hC3;
        applyStimulus(3'b100, 3'b111, 3'b001, 8'h00);
        checkOutput("mov_o1sel",  {5'd0, o1Sel}, 8'h01);
        checkOutput("mov_busy",   {7'd0, busy}, 8'h01);
        checkOutput("mov_rsel1",  {4'd0, rSel}, 8'h00);
        nextCycle();
        rdData = 8'h11;
        checkOutput("mov_rsel",   {4'd0, rSel}, 8'h01);
        checkOutput("mov_funsel", {6'd0, funSel}, 8'h01);
        checkOutput("mov_rfin",   rfInput, 8'hC3);
        checkOutput("mov_o1sel2", {5'd0, o1Sel}, 8'h00);
        nextCycle();
        checkOutput("mov_ready",  {7'd0, bus.cmd_ready}, 8'h01);
        checkOutput("mov_rfin2",  rfInput, 8'h00);

        // MOV R2 <- R2
        rdData = 8'h3C;
        applyStimulus(3'b100, 3'b101, 3'b101, 8'h00);
        checkOutput("movs_o1sel", {5'd0, o1Sel}, 8'h05);
        nextCycle();
        rdData = 8'h00;
        checkOutput("movs_rsel",  {4'd0, rSel}, 8'h04);
        checkOutput("movs_rfin",  rfInput, 8'h3C);
        nextCycle();

        // RD R3 with a stalled response; a new command is offered meanwhile
        rdData = 8'h7E;
        applyStimulus(3'b101, 3'b000, 3'b110, 8'h00);
        checkOutput("rd_o1sel",   {5'd0, o1Sel}, 8'h06);
        checkOutput("rd_rspv1",   {7'd0, bus.rsp_valid}, 8'h00);
        nextCycle();
        rdData        = 8'h00;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b001;
        bus.cmd_dst   = 3'b000;
        bus.cmd_imm   = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rd_rspv%0d", i),  {7'd0, bus.rsp_valid}, 8'h01);
            checkOutput($sformatf("rd_data%0d", i),  bus.rsp_data, 8'h7E);
            checkOutput($sformatf("rd_ready%0d", i), {7'd0, bus.cmd_ready}, 8'h00);
            checkOutput($sformatf("rd_tsel%0d", i),  {4'd0, tSel}, 8'h00);
            nextCycle();
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        checkOutput("rd_rspv_hs", {7'd0, bus.rsp_valid}, 8'h01);
        checkOutput("rd_data_hs", bus.rsp_data, 8'h7E);
        nextCycle();
        bus.rsp_ready = 1'b0;
        checkOutput("rd_rspv_done",  {7'd0, bus.rsp_valid}, 8'h00);
        checkOutput("rd_ready_done", {7'd0, bus.cmd_ready}, 8'h01);
        checkOutput("rd_tsel_done",  {4'd0, tSel}, 8'h00);

        // SUBN R3 -= 5, reset during the second strobe cycle
        applyStimulus(3'b111, 3'b110, 3'b000, 8'd5);
        checkOutput("subn_rsel1", {4'd0, rSel}, 8'h02);
        checkOutput("subn_fun1",  {6'd0, funSel}, 8'h02);
        nextCycle();
        checkOutput("subn_rsel2", {4'd0, rSel}, 8'h02);
        resetN = 1'b0;
        nextCycle();
        checkOutput("subn_rst_rsel", {4'd0, rSel}, 8'h00);
        checkOutput("subn_rst_tsel", {4'd0, tSel}, 8'h00);
        checkOutput("subn_rst_fun",  {6'd0, funSel}, 8'h00);
        checkOutput("subn_rst_busy", {7'd0, busy}, 8'h00);
        checkOutput("subn_rst_rfin", rfInput, 8'h00);
        checkOutput("subn_rst_o1",   {5'd0, o1Sel}, 8'h00);
        checkOutput("subn_rst_rspv", {7'd0, bus.rsp_valid}, 8'h00);
        resetN = 1'b1;
        nextCycle();
        checkOutput("subn_rel_ready", {7'd0, bus.cmd_ready}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("subn_after_rsel%0d", i), {4'd0, rSel}, 8'h00);
            checkOutput($sformatf("subn_after_busy%0d", i), {7'd0, busy}, 8'h00);
            nextCycle();
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/rf_cmd_sequencer.md
RF_CMD_SEQUENCER -- requirements
Module: rf_cmd_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: Clock in 1 (all state updates on rising edge); Reset in 1 (active-low, synchronous).
REQ-002 SHALL have ports cmd_valid in 1 (command offered); cmd_ready out 1 (sequencer can accept).
REQ-003 SHALL have ports cmd_op in 3 (operation); cmd_dst in 3 (destination register code); cmd_src in 3 (source register code); cmd_imm in 8 (immediate value or repeat count).
REQ-004 SHALL have ports FunSel out 2, RSel out 4, TSel out 4 and O1Sel out 3; these drive the register-file control inputs of the same names.
REQ-005 SHALL have ports RFInput out 8 (register-file load data) and rd_data in 8 (register-file Output1).
REQ-006 SHALL have ports rsp_valid out 1, rsp_data out 8 and rsp_ready in 1 (read-response handshake); busy out 1 (state not IDLE).
REQ-007 SHALL use register code 000-011 = T1-T4 and 100-111 = R1-R4, identical to the O1Sel encoding.

Function
REQ-008 SHALL use op codes 000 CLR, 001 LDI, 010 INC, 011 DEC, 100 MOV (dst<-src), 101 RD (return src), 110 ADDN (dst+=imm), 111 SUBN (dst-=imm).
REQ-009 SHALL complete a handshake on a rising edge where cmd_valid and cmd_ready are both 1; cmd_ready SHALL be 1 only in IDLE.
REQ-010 SHALL latch op, dst, src and imm at acceptance; later changes on the cmd_* inputs SHALL have no effect.
REQ-011 SHALL have FSM states IDLE, READ, WRITE, REPEAT and RESP.
REQ-012 SHALL make these transitions: IDLE->WRITE for CLR/LDI/INC/DEC; IDLE->READ for MOV/RD; IDLE->REPEAT for ADDN/SUBN with imm!=0; IDLE->IDLE for ADDN/SUBN with imm==0.
REQ-013 SHALL make these transitions: READ->WRITE for MOV; READ->RESP for RD; WRITE->IDLE; REPEAT->IDLE after the last strobe; RESP->IDLE on rsp_valid&&rsp_ready.
REQ-014 SHALL assert a write strobe for exactly one cycle, setting exactly one bit for the dst register and 0 on all other bits.
REQ-015 SHALL place the strobe in RSel (bit3=R1 ... bit0=R4) or TSel (bit3=T1 ... bit0=T4); RSel and TSel SHALL be 4'b0000 in every cycle without a strobe.
REQ-016 SHALL drive FunSel during a strobe as 00 for CLR, 01 for LDI/MOV, 11 for INC/ADDN and 10 for DEC/SUBN; outside a strobe FunSel SHALL be 00.
REQ-017 SHALL drive RFInput to imm during an LDI strobe and to the captured source value during a MOV strobe; otherwise RFInput SHALL be 0.
REQ-018 SHALL drive O1Sel=src in READ and capture rd_data at the end of READ; O1Sel SHALL be 000 in all other states.
REQ-019 SHALL give CLR/LDI/INC/DEC, accepted at edge T, the strobe in cycle T+1 and cmd_ready=1 again at T+2.
REQ-020 SHALL give MOV READ in cycle T+1, the strobe in T+2 and cmd_ready at T+3.
REQ-021 SHALL give RD READ in cycle T+1 and rsp_valid=1 from T+2, with rsp_data stable until the handshake.
REQ-022 SHALL give ADDN/SUBN with imm=n exactly n strobes on consecutive cycles T+1..T+n, using an 8-bit down-counter, with cmd_ready at T+n+1.
REQ-023 SHALL handle ADDN/SUBN with imm=0 with no strobe and cmd_ready back at T+1.
REQ-024 SHALL leave wrap-around to the register file (8-bit modulo) and SHALL NOT check for overflow.
REQ-025 SHALL treat dst==src for MOV as legal: one read and one write-back of the same value.
REQ-026 SHALL, in RESP, hold rsp_valid with no timeout while rsp_ready is 0, and SHALL accept no new command.

Reset
REQ-027 SHALL, while Reset is 0 at a rising edge, set the state to IDLE, RSel/TSel/FunSel/O1Sel to 0, RFInput to 0, rsp_valid/rsp_data to 0, busy to 0 and the counter to 0; cmd_ready SHALL be 1 in the first cycle after release.
REQ-028 SHALL abort any in-progress command on reset, issue no further strobes for it and drop any pending response.

Structure
REQ-029 SHALL keep in shared package rf_seq_pkg: the op-code enum, the FSM state enum, register-code constants and the FunSel constants (CLR=00, LD=01, DEC=10, INC=11).
REQ-030 SHALL instantiate sub-module rf_sel_decoder (3-bit code + enable -> 4-bit RSel, 4-bit TSel), which is purely combinational.

Verification
REQ-031 SHALL cover: LDI dst=100 imm=8'h5A -> in T+1 RSel=1000, FunSel=01, RFInput=5A, and TSel=0000.
REQ-032 SHALL cover: ADDN dst=011 imm=3 -> TSel=0001, FunSel=11 for exactly 3 consecutive cycles, then cmd_ready=1.
REQ-033 SHALL cover: ADDN imm=0 -> no strobe, busy=1 for zero cycles, and cmd_ready=1 at T+1.
REQ-034 SHALL cover: MOV dst=111 src=001 with rd_data=8'hC3 during READ -> O1Sel=001 in T+1, then RSel=0001, FunSel=01, RFInput=C3 in T+2.
REQ-035 SHALL cover: RD src=110 with rd_data=8'h7E and rsp_ready held 0 for 4 cycles -> rsp_valid=1 and rsp_data=7E held until rsp_ready=1, and cmd_ready=0 meanwhile.
REQ-036 SHALL cover: Reset=0 in the second REPEAT cycle of SUBN imm=5 -> no further strobes, all outputs 0, and cmd_ready=1 after release.
